// File: rtl/spi_master.sv
// SPI master: one TX write launches a full-duplex LSB-first frame of DATA_W bits.
// Completion sets ready, latches the received word and pulses interrupt for one clk.
module spi_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 2,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] address,
  input  logic              we,
  input  logic              sel,
  output logic              interrupt
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TX     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_RX     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_DIV    = ADDR_W'(3);

  logic [2:0]        state;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  hlim;
  logic [DIV_W-1:0]  hcnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_data;
  logic              ready;
  logic              busy;
  logic              wr_en;
  logic              rd_en;
  logic              tx_start;
  logic              expire;
  logic              sample;

  assign wr_en    = sel & we;
  assign rd_en    = sel & ~we;
  assign tx_start = wr_en && (address == ADDR_TX) && (state == IDLE);
  assign expire   = (hcnt == hlim);
  assign sample   = ((state == SETUP) || (state == LOW)) && expire;

  // Control path: FSM, wire outputs and CPU-visible status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sclk      <= 1'b0;
      ss        <= 1'b1;
      mosi      <= 1'b0;
      interrupt <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      div       <= DIV_W'(DIV_RST);
      rx_data   <= '0;
      bit_cnt   <= '0;
      hcnt      <= '0;
    end else begin
      interrupt <= 1'b0;
      if (wr_en && (address == ADDR_DIV)) div <= data_in[DIV_W-1:0];
      // A frame-end set below overrides this clear when both land together
      if (rd_en && (address == ADDR_RX)) ready <= 1'b0;
      if (state != IDLE) hcnt <= expire ? '0 : hcnt + 1'b1;
      case (state)
        IDLE: begin
          if (tx_start) begin
            ss      <= 1'b0;
            mosi    <= data_in[0];
            busy    <= 1'b1;
            bit_cnt <= '0;
            hcnt    <= '0;
            state   <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (expire) begin
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (expire) begin
            sclk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end else begin
              mosi    <= tx_sr[1];
              bit_cnt <= bit_cnt + 1'b1;
              state   <= LOW;
            end
          end
        end
        HOLD: begin
          if (expire) begin
            ss        <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
            rx_data   <= rx_sr;
            interrupt <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: shift registers and the per-frame divider snapshot
  always_ff @(posedge clk) begin
    if (tx_start) begin
      tx_sr <= data_in;
      hlim  <= div;
    end else if ((state == HIGH) && expire) begin
      tx_sr <= tx_sr >> 1;
    end
    if (sample) rx_sr <= {miso, rx_sr[DATA_W-1:1]};
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_STATUS: data_out[1:0]       = {busy, ready};
      ADDR_RX:     data_out            = rx_data;
      ADDR_DIV:    data_out[DIV_W-1:0] = div;
      default:     data_out            = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master (DATA_W=8): vector table, directed corner sequences and random
// frames against a wire-level slave model and frame-rule expectations.
module tb_spi_master;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk;
  logic          ss;
  logic          mosi;
  logic          miso = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [1:0]    address = 2'd0;
  logic          we = 1'b0;
  logic          sel = 1'b0;
  logic          interrupt;

  spi_master #(.DATA_W(DW), .ADDR_W(2), .DIV_W(8), .DIV_RST(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .data_in(data_in), .data_out(data_out), .address(address), .we(we),
    .sel(sel), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Wire monitor + slave model state
  logic          prev_ss = 1'b1;
  logic          prev_sclk = 1'b0;
  logic          prev_mosi = 1'b0;
  int            ss_cnt = 0;
  int            lvl_cnt = 0;
  int            lvl_err = 0;
  int            rises = 0;
  int            falls = 0;
  int            irq_cnt = 0;
  int            cur_h = 1;
  logic [DW-1:0] mosi_word = '0;
  logic [DW-1:0] slave_word = '0;
  logic          slave_irq = 1'b0;

  always @(negedge clk) begin
    prev_ss   <= ss;
    prev_sclk <= sclk;
    prev_mosi <= mosi;
    if (interrupt) irq_cnt <= irq_cnt + 1;
    if (rst) begin
      irq_cnt <= 0;
      miso    <= slave_word[0];
    end else if (prev_ss && !ss) begin
      ss_cnt    <= 1;
      lvl_cnt   <= 1;
      lvl_err   <= 0;
      rises     <= 0;
      falls     <= 0;
      irq_cnt   <= 0;
      mosi_word <= '0;
      slave_irq <= 1'b0;
    end else if (!ss) begin
      ss_cnt <= ss_cnt + 1;
      if (sclk != prev_sclk) begin
        if (lvl_cnt != cur_h) lvl_err <= lvl_err + 1;
        lvl_cnt <= 1;
        if (sclk) begin
          rises <= rises + 1;
          if (mosi != prev_mosi) lvl_err <= lvl_err + 1;
        end else begin
          falls     <= falls + 1;
          mosi_word <= {prev_mosi, mosi_word[DW-1:1]};
          if (falls + 1 < DW) miso <= slave_word[falls + 1];
        end
      end else begin
        lvl_cnt <= lvl_cnt + 1;
        if (mosi != prev_mosi) lvl_err <= lvl_err + 1;
      end
    end else begin
      if (!prev_ss) begin
        if (lvl_cnt != cur_h) lvl_err <= lvl_err + 1;
        if (falls == DW) slave_irq <= 1'b1;
      end
      miso <= slave_word[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d);
    address = a;
    data_in = d;
    sel = 1'b1;
    we = 1'b1;
    @(posedge clk);
    #1;
    sel = 1'b0;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [DW-1:0] d);
    address = a;
    we = 1'b0;
    sel = 1'b1;
    #1;
    d = data_out;
    @(posedge clk);
    #1;
    sel = 1'b0;
  endtask

  task automatic start_frame(input logic [DW-1:0] tx, input logic [DW-1:0] stx, input int h);
    slave_word = stx;
    cur_h = h;
    @(posedge clk);
    #1;
    bus_write(2'd1, tx);
  endtask

  task automatic finish_frame(input string name, input logic [DW-1:0] etx,
                              input logic [DW-1:0] erx, input int ess);
    logic [DW-1:0] d;
    int n = 0;
    while (interrupt !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, n < 5000, 1);
    repeat (2) @(negedge clk);
    chk({name, "_ss_low"}, ss_cnt, ess);
    chk({name, "_timing"}, lvl_err, 0);
    chk({name, "_mosi"}, mosi_word, etx);
    chk({name, "_edges"}, {rises[15:0], falls[15:0]}, {16'(DW), 16'(DW)});
    chk({name, "_irq"}, irq_cnt, 1);
    chk({name, "_slave_irq"}, slave_irq, 1);
    bus_read(2'd0, d);
    chk({name, "_status"}, d, 1);
    bus_read(2'd2, d);
    chk({name, "_rx"}, d, erx);
    bus_read(2'd0, d);
    chk({name, "_status_clr"}, d, 0);
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] stx;
    int            div;
    logic [DW-1:0] exp_rx;
    int            exp_ss;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] rtx;
    logic [DW-1:0] rstx;
    int rdiv;
    int n;

    vecs[0] = '{8'hA5, 8'h3C, 0, 8'h3C, 17};
    vecs[1] = '{8'h81, 8'h7E, 3, 8'h7E, 68};
    vecs[2] = '{8'hC3, 8'h5A, 0, 8'h5A, 17};
    vecs[3] = '{8'h00, 8'hFF, 1, 8'hFF, 34};
    vecs[4] = '{8'hFF, 8'h00, 2, 8'h00, 51};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss", ss, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_irq", interrupt, 0);
    rst = 1'b0;
    bus_read(2'd0, d);
    chk("rst_status", d, 0);
    bus_read(2'd3, d);
    chk("rst_div", d, 4);
    bus_read(2'd2, d);
    chk("rst_rx", d, 0);
    bus_read(2'd1, d);
    chk("unmapped_tx_read", d, 0);

    for (int i = 0; i < 5; i++) begin
      bus_write(2'd3, 8'(vecs[i].div));
      start_frame(vecs[i].tx, vecs[i].stx, vecs[i].div + 1);
      finish_frame($sformatf("vec%0d", i), vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_ss);
    end

    // TX and DIV writes in mid-frame: old data/timing kept, new div applies next frame
    bus_write(2'd3, 8'd3);
    start_frame(8'h3C, 8'h96, 4);
    repeat (10) @(posedge clk);
    #1;
    bus_write(2'd1, 8'hFF);
    bus_write(2'd3, 8'd1);
    bus_read(2'd2, d);
    chk("mid_rx_stable", d, 8'h00);
    finish_frame("mid", 8'h3C, 8'h96, 68);
    bus_read(2'd3, d);
    chk("mid_div_new", d, 1);
    start_frame(8'h5A, 8'h11, 2);
    finish_frame("after_mid", 8'h5A, 8'h11, 34);

    // RX read landing on the completion edge: set wins
    bus_write(2'd3, 8'd0);
    bus_read(2'd2, d);
    start_frame(8'h96, 8'hE1, 1);
    repeat (16) @(posedge clk);
    #1;
    address = 2'd2;
    we = 1'b0;
    sel = 1'b1;
    @(posedge clk);
    #1;
    sel = 1'b0;
    chk("same_cycle_irq", interrupt, 1);
    repeat (2) @(negedge clk);
    chk("same_cycle_ss_low", ss_cnt, 17);
    bus_read(2'd0, d);
    chk("same_cycle_ready", d, 1);
    bus_read(2'd2, d);
    chk("same_cycle_rx", d, 8'hE1);
    bus_read(2'd0, d);
    chk("same_cycle_clear", d, 0);

    for (int i = 0; i < 6; i++) begin
      rdiv = int'($urandom_range(0, 3));
      rtx  = 8'($urandom);
      rstx = 8'($urandom);
      bus_write(2'd3, 8'(rdiv));
      start_frame(rtx, rstx, rdiv + 1);
      finish_frame($sformatf("rand%0d", i), rtx, rstx, (2 * DW + 1) * (rdiv + 1));
    end

    // Reset mid-frame after the third rising sclk edge
    bus_write(2'd3, 8'd2);
    start_frame(8'hFF, 8'h33, 3);
    n = 0;
    while (rises < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_rise3", n < 1000, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_ss", ss, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_irq", interrupt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_irq", irq_cnt, 0);
    chk("abort_ss_idle", ss, 1);
    bus_read(2'd0, d);
    chk("abort_status", d, 0);
    bus_read(2'd3, d);
    chk("abort_div", d, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
